pipe_ctrl: RTL and testbench

- Central pipeline-control unit that drives the per-segment `stall` / `refresh` pairs consumed by the if_id, id_ex, ex_mem and mem_wb segment registers.
- Detects load-use and CP0-read hazards, sequences multi-cycle mult/div occupancy of EX, and freezes the pipe on outstanding instruction fetches and data-memory accesses.
- Performs exception/eret flushes, including discarding an in-flight fetch.
- Sits beside the datapath; takes only control inputs from ID, EX, MEM and the SRAM handshake.

---
 rtl/pipe_pkg.sv | 16 +
 rtl/md_seq.sv | 114 +++++++++++
 rtl/pipe_ctrl.sv | 101 ++++++++++
 tb/tb_pipe_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and defaults for the pipeline control unit.
// State encoding is shared between pipe_ctrl and md_seq.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MD_RUN  = 2'd1,
        ST_MD_WAIT = 2'd2,
        ST_DISCARD = 2'd3
    } state_t;

    localparam int DIV_CYCLES_DEF = 33;
    localparam int MUL_CYCLES_DEF = 2;
    localparam int CNT_W_DEF      = 6;

endpackage

// File: rtl/md_seq.sv
// Control FSM: mult/div occupancy of EX plus the fetch-discard state.
// Flush handling lives here because it decides the next state.
module md_seq
    import pipe_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic   clk,
    input  logic   resetn,
    input  logic   i_div,
    input  logic   i_mult,
    input  logic   i_stall_mem,
    input  logic   i_flush,
    input  logic   i_fetch_pend,
    input  logic   i_inst_ok,
    output state_t o_state,
    output logic   o_md_haz,
    output logic   o_md_start,
    output logic   o_md_done,
    output logic   o_md_cancel
);

    localparam bit DIV_LONG = DIV_CYCLES > 1;
    localparam bit MUL_LONG = MUL_CYCLES > 1;
    localparam logic [CNT_W-1:0] DIV_LOAD =
        DIV_LONG ? CNT_W'(DIV_CYCLES - 2) : '0;
    localparam logic [CNT_W-1:0] MUL_LOAD =
        MUL_LONG ? CNT_W'(MUL_CYCLES - 2) : '0;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;

    logic             w_md_op;
    logic             w_long;
    logic             w_last;
    logic [CNT_W-1:0] w_load;
    state_t           w_flush_nxt;

    assign w_md_op     = i_div | i_mult;
    assign w_long      = i_div ? DIV_LONG : (i_mult & MUL_LONG);
    assign w_load      = i_div ? DIV_LOAD : MUL_LOAD;
    assign w_last      = (r_cnt == '0);
    assign w_flush_nxt = i_fetch_pend ? ST_DISCARD : ST_IDLE;
    assign o_state     = r_state;

    // The final EX cycle (cnt==0) no longer stalls, so EX holds exactly N cycles.
    always_comb begin
        o_md_haz    = 1'b0;
        o_md_start  = 1'b0;
        o_md_done   = 1'b0;
        o_md_cancel = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                o_md_haz   = w_md_op & w_long;
                o_md_start = w_md_op & ~i_flush;
                o_md_done  = w_md_op & ~w_long & ~i_flush;
            end
            ST_MD_RUN: begin
                o_md_haz    = ~w_last;
                o_md_done   = w_last & ~i_flush;
                o_md_cancel = i_flush;
            end
            ST_MD_WAIT: begin
                o_md_done   = ~i_flush;
                o_md_cancel = i_flush;
            end
            ST_DISCARD: ;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (i_flush) begin
                        r_state <= w_flush_nxt;
                    end else if (w_md_op && w_long) begin
                        r_cnt   <= w_load;
                        r_state <= ST_MD_RUN;
                    end
                end
                ST_MD_RUN: begin
                    if (i_flush) begin
                        r_state <= w_flush_nxt;
                    end else if (w_last) begin
                        r_state <= i_stall_mem ? ST_MD_WAIT : ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_MD_WAIT: begin
                    if (i_flush) begin
                        r_state <= w_flush_nxt;
                    end else if (!i_stall_mem) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_DISCARD: begin
                    if (!i_flush && i_inst_ok) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: hazard detection and per-segment stall/refresh.
// Outputs are forced low while resetn is asserted.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       id_rs_ren,
    input  logic       id_rt_ren,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       ex_load,
    input  logic       ex_cp0ren,
    input  logic       ex_regwen,
    input  logic [4:0] ex_wreg,
    input  logic       ex_mult,
    input  logic       ex_div,
    input  logic       fetch_busy,
    input  logic       inst_data_ok,
    input  logic       data_busy,
    input  logic       exc_flush,
    output logic       stall_if,
    output logic       stall_id,
    output logic       stall_ex,
    output logic       stall_mem,
    output logic       refresh_id,
    output logic       refresh_ex,
    output logic       refresh_mem,
    output logic       refresh_wb,
    output logic       md_start,
    output logic       md_done,
    output logic       md_cancel,
    output logic       if_discard
);

    state_t w_state;
    logic   w_md_haz;
    logic   w_md_start;
    logic   w_md_done;
    logic   w_md_cancel;
    logic   w_ls_haz;
    logic   w_discard;
    logic   w_stall_if;
    logic   w_stall_id;
    logic   w_stall_ex;
    logic   w_stall_mem;
    logic   w_flush;

    md_seq #(
        .DIV_CYCLES (DIV_CYCLES),
        .MUL_CYCLES (MUL_CYCLES),
        .CNT_W      (CNT_W)
    ) u_md_seq (
        .clk          (clk),
        .resetn       (resetn),
        .i_div        (ex_div),
        .i_mult       (ex_mult),
        .i_stall_mem  (data_busy),
        .i_flush      (exc_flush),
        .i_fetch_pend (fetch_busy & ~inst_data_ok),
        .i_inst_ok    (inst_data_ok),
        .o_state      (w_state),
        .o_md_haz     (w_md_haz),
        .o_md_start   (w_md_start),
        .o_md_done    (w_md_done),
        .o_md_cancel  (w_md_cancel)
    );

    assign w_ls_haz = (ex_load | ex_cp0ren) & ex_regwen
                    & (ex_wreg != 5'd0)
                    & ((id_rs_ren & (id_rs == ex_wreg))
                     | (id_rt_ren & (id_rt == ex_wreg)));

    assign w_discard   = (w_state == ST_DISCARD);
    assign w_stall_mem = data_busy;
    assign w_stall_ex  = w_stall_mem | w_md_haz;
    assign w_stall_id  = w_stall_ex | w_ls_haz;
    assign w_stall_if  = w_stall_id | fetch_busy | w_discard;
    assign w_flush     = exc_flush;

    // A flush clears every segment; only IF keeps waiting on its fetch.
    assign stall_if    = resetn & (w_flush ? (fetch_busy | w_discard)
                                           : w_stall_if);
    assign stall_id    = resetn & ~w_flush & w_stall_id;
    assign stall_ex    = resetn & ~w_flush & w_stall_ex;
    assign stall_mem   = resetn & ~w_flush & w_stall_mem;
    assign refresh_id  = resetn & (w_flush | w_discard
                                 | (w_stall_if & ~w_stall_id));
    assign refresh_ex  = resetn & (w_flush | (w_stall_id & ~w_stall_ex));
    assign refresh_mem = resetn & (w_flush | (w_stall_ex & ~w_stall_mem));
    assign refresh_wb  = resetn & (w_flush | w_stall_mem);
    assign md_start    = resetn & w_md_start;
    assign md_done     = resetn & w_md_done;
    assign md_cancel   = resetn & w_md_cancel;
    assign if_discard  = resetn & w_discard;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus random traffic,
// all checked against a remaining-cycles behavioural model.
module tb_pipe_ctrl;

    localparam int DIVC = 33;
    localparam int MULC = 2;

    logic clk = 1'b0;
    logic resetn;
    logic id_rs_ren, id_rt_ren;
    logic [4:0] id_rs, id_rt, ex_wreg;
    logic ex_load, ex_cp0ren, ex_regwen, ex_mult, ex_div;
    logic fetch_busy, inst_data_ok, data_busy, exc_flush;

    logic s_if, s_id, s_ex, s_mem, r_id, r_ex, r_mem, r_wb;
    logic m_st, m_dn, m_cn, i_dc;
    logic t_if, t_id, t_ex, t_mem, q_id, q_ex, q_mem, q_wb;
    logic n_st, n_dn, n_cn, n_dc;

    logic [11:0] outs, outs1;
    logic [11:0] got, got1, e_vec;

    int n_tests = 0;
    int n_fail  = 0;

    bit m_run, m_wait, m_disc;
    int m_rem;
    bit x_run, x_wait, x_disc;
    int x_rem;

    always #5 clk = ~clk;

    assign outs  = {s_if, s_id, s_ex, s_mem, r_id, r_ex, r_mem, r_wb,
                    m_st, m_dn, m_cn, i_dc};
    assign outs1 = {t_if, t_id, t_ex, t_mem, q_id, q_ex, q_mem, q_wb,
                    n_st, n_dn, n_cn, n_dc};

    pipe_ctrl #(.DIV_CYCLES(DIVC), .MUL_CYCLES(MULC), .CNT_W(6)) u_dut (
        .clk(clk), .resetn(resetn),
        .id_rs_ren(id_rs_ren), .id_rt_ren(id_rt_ren),
        .id_rs(id_rs), .id_rt(id_rt),
        .ex_load(ex_load), .ex_cp0ren(ex_cp0ren), .ex_regwen(ex_regwen),
        .ex_wreg(ex_wreg), .ex_mult(ex_mult), .ex_div(ex_div),
        .fetch_busy(fetch_busy), .inst_data_ok(inst_data_ok),
        .data_busy(data_busy), .exc_flush(exc_flush),
        .stall_if(s_if), .stall_id(s_id), .stall_ex(s_ex),
        .stall_mem(s_mem), .refresh_id(r_id), .refresh_ex(r_ex),
        .refresh_mem(r_mem), .refresh_wb(r_wb), .md_start(m_st),
        .md_done(m_dn), .md_cancel(m_cn), .if_discard(i_dc)
    );

    pipe_ctrl #(.DIV_CYCLES(DIVC), .MUL_CYCLES(1), .CNT_W(6)) u_dut1 (
        .clk(clk), .resetn(resetn),
        .id_rs_ren(id_rs_ren), .id_rt_ren(id_rt_ren),
        .id_rs(id_rs), .id_rt(id_rt),
        .ex_load(ex_load), .ex_cp0ren(ex_cp0ren), .ex_regwen(ex_regwen),
        .ex_wreg(ex_wreg), .ex_mult(ex_mult), .ex_div(ex_div),
        .fetch_busy(fetch_busy), .inst_data_ok(inst_data_ok),
        .data_busy(data_busy), .exc_flush(exc_flush),
        .stall_if(t_if), .stall_id(t_id), .stall_ex(t_ex),
        .stall_mem(t_mem), .refresh_id(q_id), .refresh_ex(q_ex),
        .refresh_mem(q_mem), .refresh_wb(q_wb), .md_start(n_st),
        .md_done(n_dn), .md_cancel(n_cn), .if_discard(n_dc)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_wait = 0; m_disc = 0; m_rem = 0;
    endtask

    // Model tracks how many EX cycles the md op still needs (incl. this one).
    task automatic model_eval();
        bit ls, mdop, starting, occ, haz, sm, se, sid, sif;
        int n, rem_now;
        ls = (ex_load | ex_cp0ren) && ex_regwen && ex_wreg != 0 &&
             ((id_rs_ren && id_rs == ex_wreg) ||
              (id_rt_ren && id_rt == ex_wreg));
        mdop     = ex_div | ex_mult;
        n        = ex_div ? DIVC : MULC;
        starting = !m_run && !m_wait && !m_disc && mdop;
        rem_now  = m_run ? m_rem : n;
        occ      = m_run || starting;
        haz      = occ && rem_now > 1;
        sm  = data_busy;
        se  = sm | haz;
        sid = se | ls;
        sif = sid | fetch_busy | m_disc;
        x_run = m_run; x_wait = m_wait; x_disc = m_disc; x_rem = m_rem;
        if (exc_flush) begin
            e_vec = {fetch_busy | m_disc, 3'b000, 4'b1111, 1'b0, 1'b0,
                     m_run | m_wait, m_disc};
            x_run = 0; x_wait = 0;
            x_disc = m_disc ? 1'b1 : (fetch_busy && !inst_data_ok);
        end else begin
            e_vec = {sif, sid, se, sm, (sif & !sid) | m_disc, sid & !se,
                     se & !sm, sm, starting,
                     (occ && rem_now == 1) || m_wait, 1'b0, m_disc};
            if (m_disc) begin
                if (inst_data_ok) x_disc = 0;
            end else if (occ) begin
                if (rem_now == 1) begin
                    x_wait = m_run && data_busy;
                    x_run  = 0;
                end else begin
                    x_run = 1;
                    x_rem = rem_now - 1;
                end
            end else if (m_wait) begin
                if (!data_busy) x_wait = 0;
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        model_eval();
        got  = outs;
        got1 = outs1;
        chk("cycle_outs", 32'(got), 32'(e_vec));
        @(posedge clk);
        m_run = x_run; m_wait = x_wait; m_disc = x_disc; m_rem = x_rem;
        #1;
    endtask

    task automatic quiet();
        id_rs_ren = 0; id_rt_ren = 0; id_rs = 0; id_rt = 0;
        ex_load = 0; ex_cp0ren = 0; ex_regwen = 0; ex_wreg = 0;
        ex_mult = 0; ex_div = 0; fetch_busy = 0; inst_data_ok = 0;
        data_busy = 0; exc_flush = 0;
    endtask

    task automatic rand_inputs();
        int op;
        id_rs_ren    = 1'($urandom_range(0, 1));
        id_rt_ren    = 1'($urandom_range(0, 1));
        id_rs        = 5'($urandom_range(0, 3));
        id_rt        = 5'($urandom_range(0, 3));
        ex_wreg      = 5'($urandom_range(0, 3));
        ex_load      = ($urandom_range(0, 3) == 0);
        ex_cp0ren    = ($urandom_range(0, 7) == 0);
        ex_regwen    = 1'($urandom_range(0, 1));
        op           = $urandom_range(0, 99);
        ex_div       = (op < 4);
        ex_mult      = (op >= 4 && op < 12);
        fetch_busy   = ($urandom_range(0, 9) < 3);
        inst_data_ok = 1'($urandom_range(0, 1));
        data_busy    = ($urandom_range(0, 4) == 0);
        exc_flush    = ($urandom_range(0, 29) == 0);
    endtask

    initial begin
        int nst, nrf, fdn, ndn, ndc;
        resetn = 0;
        quiet();
        id_rs_ren = 1; id_rs = 5; ex_load = 1; ex_regwen = 1;
        ex_wreg = 5; ex_div = 1; fetch_busy = 1; data_busy = 1;
        exc_flush = 1;
        model_reset();
        #3;
        chk("reset_outs", 32'(outs), 0);
        chk("reset_outs_mul1", 32'(outs1), 0);
        @(posedge clk);
        #1;
        quiet();
        resetn = 1;

        // Single-cycle mult build: no stall, start and done together.
        ex_mult = 1;
        cyc();
        chk("mul1_no_stall", 32'({got1[9], got1[3], got1[2]}), 32'h3);
        ex_mult = 0;
        cyc();
        cyc();

        // Load-use hazard.
        ex_load = 1; ex_regwen = 1; ex_wreg = 5; id_rs = 5; id_rs_ren = 1;
        cyc();
        chk("lu_stall", 32'({got[11], got[10], got[9], got[6]}), 32'hD);
        fetch_busy = 1;
        cyc();
        chk("lu_fetch", 32'({got[7], got[6]}), 32'h1);
        fetch_busy = 0; ex_wreg = 0; id_rs = 0;
        cyc();
        chk("lu_r0", 32'(got[10]), 0);
        quiet();
        cyc();

        // Divide, MEM free.
        nst = 0; nrf = 0; fdn = 0;
        ex_div = 1;
        for (int c = 1; c <= DIVC; c++) begin
            cyc();
            if (got[9]) nst++;
            if (got[5]) nrf++;
            if (got[2] && fdn == 0) fdn = c;
        end
        ex_div = 0;
        cyc();
        chk("div_stall_cycles", 32'(nst), 32);
        chk("div_refresh_mem", 32'(nrf), 32);
        chk("div_done_cycle", 32'(fdn), 33);

        // Divide overlapping a data-memory stall.
        fdn = 0; ndn = 0;
        ex_div = 1;
        for (int c = 1; c <= 38; c++) begin
            data_busy = (c >= 30 && c <= 36);
            ex_div    = (c <= 37);
            cyc();
            if (got[2]) begin
                ndn++;
                if (fdn == 0) fdn = c;
            end
        end
        chk("ovl_done_first", 32'(fdn), 33);
        chk("ovl_done_count", 32'(ndn), 5);
        quiet();

        // Exception during divide.
        ex_div = 1;
        for (int c = 1; c <= 9; c++) cyc();
        exc_flush = 1;
        cyc();
        chk("exc_div", 32'(got[7:1]), 32'b1111001);
        quiet();
        ndn = 0;
        for (int c = 0; c < 4; c++) begin
            cyc();
            if (got[2]) ndn++;
        end
        chk("exc_div_no_done", 32'(ndn), 0);

        // Exception with a fetch in flight.
        fetch_busy = 1; exc_flush = 1;
        cyc();
        chk("exc_fetch_stall_if", 32'(got[11]), 1);
        exc_flush = 0;
        ndc = 0;
        for (int c = 0; c < 3; c++) begin
            cyc();
            if (got[0] && got[11] && got[7]) ndc++;
        end
        chk("discard_hold", 32'(ndc), 3);
        inst_data_ok = 1;
        cyc();
        chk("discard_last", 32'(got[0]), 1);
        quiet();
        cyc();
        chk("discard_exit", 32'({got[11], got[0]}), 0);

        // Asynchronous reset in the middle of a divide.
        ex_div = 1;
        for (int c = 0; c < 5; c++) cyc();
        #2;
        resetn = 0;
        #1;
        chk("async_reset", 32'(outs), 0);
        model_reset();
        @(posedge clk);
        #1;
        quiet();
        resetn = 1;
        cyc();
        ex_mult = 1;
        cyc();
        ex_mult = 0;
        cyc();

        for (int k = 0; k < 3000; k++) begin
            rand_inputs();
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
